// File: rtl/gb_apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// gb_apu_frame_sequencer
//
// Derives the 512 Hz DIV-APU event from the live DIV register and turns it
// into single-cycle tick strobes for the length (256 Hz), sweep (128 Hz) and
// envelope (64 Hz) function units. The index of the next step to run and the
// length-phase flag are exported so the channels can apply their trigger-time
// length quirks.
//
// Ports
//   clk             system clock, all state on posedge
//   reset           asynchronous reset, active low
//   apu_enable      master power; while low, events are dropped and step held at 0
//   double_speed    CPU double-speed mode; selects the DOUBLE_BIT of div
//   div             live DIV register value
//   clk_length_ctr  1-cycle strobe, length tick
//   clk_sweep       1-cycle strobe, sweep tick
//   clk_envelope    1-cycle strobe, envelope tick
//   step            index of the next step to execute (0..7)
//   length_skip     1 when the next step does not clock length (= step[0])
// -----------------------------------------------------------------------------
module gb_apu_frame_sequencer #(
   parameter int DIV_WIDTH  = 8,
   parameter int NORMAL_BIT = 4,
   parameter int DOUBLE_BIT = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 apu_enable,
   input  logic                 double_speed,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 clk_length_ctr,
   output logic                 clk_sweep,
   output logic                 clk_envelope,
   output logic [2:0]           step,
   output logic                 length_skip
);

   logic       sel;
   logic       sel_q;
   logic       ds_q;
   logic       mode_switch;
   logic       apu_event;

   logic [2:0] step_reg;
   logic [2:0] step_next;
   logic       len_reg;
   logic       len_next;
   logic       sweep_reg;
   logic       sweep_next;
   logic       env_reg;
   logic       env_next;

   // Only the two selectable bits of div are observed; the rest is folded
   // here so the full-width port stays connected.
   logic       unused_div;
   assign unused_div = ^div;

   assign sel = double_speed ? div[DOUBLE_BIT] : div[NORMAL_BIT];

   // Changing speed swaps which div bit is watched; the old and new bits may
   // disagree, which must not be mistaken for a falling edge.
   assign mode_switch = double_speed ^ ds_q;
   assign apu_event   = sel_q & ~sel & ~mode_switch;

   // Step table for the step value being executed:
   //   even steps clock length, steps 2 and 6 add sweep, step 7 is envelope.
   always_comb begin
      step_next  = step_reg;
      len_next   = 1'b0;
      sweep_next = 1'b0;
      env_next   = 1'b0;
      if (!apu_enable) begin
         step_next = 3'd0;
      end else if (apu_event) begin
         step_next  = step_reg + 3'd1;
         len_next   = ~step_reg[0];
         sweep_next = (step_reg[1:0] == 2'b10);
         env_next   = (step_reg == 3'd7);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q     <= 1'b0;
         ds_q      <= 1'b0;
         step_reg  <= 3'd0;
         len_reg   <= 1'b0;
         sweep_reg <= 1'b0;
         env_reg   <= 1'b0;
      end else begin
         // sel_q tracks div even while powered down so that re-enabling
         // does not see a stale edge.
         sel_q     <= sel;
         ds_q      <= double_speed;
         step_reg  <= step_next;
         len_reg   <= len_next;
         sweep_reg <= sweep_next;
         env_reg   <= env_next;
      end
   end

   assign clk_length_ctr = len_reg;
   assign clk_sweep      = sweep_reg;
   assign clk_envelope   = env_reg;
   assign step           = step_reg;
   assign length_skip    = step_reg[0];

endmodule
